// File: rtl/bcd_digit_sequencer_pkg.sv
// Shared definitions for the BCD digit sequencer: widths, limits, FSM states
// and the remainder range test.
package bcd_digit_sequencer_pkg;

    localparam int unsigned WIDTH       = 13;         // binary operand width
    localparam int unsigned DIGITS      = 4;          // BCD output digits
    localparam int unsigned DIV_CONST   = 10;         // decimal radix
    localparam int unsigned MAX_FIX     = 63;         // corrections per digit before err
    localparam int unsigned REM_W       = WIDTH + 1;  // signed remainder width
    localparam int unsigned DIGITS_W    = 4 * DIGITS; // packed digit bus width
    localparam logic [3:0]  DIGIT_BLANK = 4'hF;       // segment decoder blank code

    typedef enum logic [2:0] {
        S_IDLE,
        S_EST,
        S_FIX,
        S_STORE,
        S_FIN
    } state_e;

    // A negative two's-complement remainder reads as a large unsigned value,
    // so one unsigned compare covers both 0 <= r and r <= 9.
    function automatic logic rem_in_range(input logic signed [REM_W-1:0] r);
        return $unsigned(r) <= REM_W'(DIV_CONST - 1);
    endfunction

endpackage

// File: rtl/bcd_digit_sequencer_div10_estimate.sv
// Combinational divide-by-ten estimate: q_est = x/8 - x/16 + x/32 (~0.094*x).
// The estimate may be off by several units; the sequencer corrects it.
// Ports:
//   x_i      operand
//   q_est_c  quotient estimate (combinational)
module bcd_digit_sequencer_div10_estimate
    import bcd_digit_sequencer_pkg::*;
(
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] q_est_c
);

    // x/8 >= x/16, so the difference never wraps before the final add.
    assign q_est_c = (x_i >> 3) - (x_i >> 4) + (x_i >> 5);

endmodule

// File: rtl/bcd_digit_sequencer.sv
// Converts a 13-bit binary value into four BCD digits, one digit per pass,
// reusing a single divide-by-ten estimator and correcting q/r one step per
// cycle until the remainder is a valid digit.
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous active-high reset
//   start   conversion request, sampled only when idle
//   value   binary operand, captured on an accepted start
//   busy    high from the cycle after an accepted start until done
//   done    one-cycle pulse, digits valid from this cycle on
//   digits  {thousands, hundreds, tens, ones}
//   err     a digit needed more than MAX_FIX corrections
// Build option: LEADING_ZERO_BLANK_EN replaces leading zero digits (never the
// ones digit) with the blank code when the conversion finishes.
module bcd_digit_sequencer
    import bcd_digit_sequencer_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [WIDTH-1:0]    value,
    output logic                busy,
    output logic                done,
    output logic [DIGITS_W-1:0] digits,
    output logic                err
);

    localparam int unsigned FIX_W = $clog2(MAX_FIX + 1);
    localparam int unsigned IDX_W = $clog2(DIGITS);
    localparam logic signed [REM_W-1:0] TEN_S = REM_W'(DIV_CONST);

    state_e                    state_q, state_d;
    logic [WIDTH-1:0]          x_q, x_d;
    logic [WIDTH-1:0]          q_q, q_d;
    logic signed [REM_W-1:0]   r_q, r_d;
    logic [FIX_W-1:0]          fix_q, fix_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;
    logic [DIGITS_W-1:0]       digits_q, digits_d;

    logic [WIDTH-1:0]          q_est_c;
    logic signed [REM_W-1:0]   r_est_c;
    logic signed [REM_W-1:0]   r_adj_c;
    logic [WIDTH-1:0]          q_adj_c;
`ifdef LEADING_ZERO_BLANK_EN
    logic                      lead_c;
`endif

    bcd_digit_sequencer_div10_estimate u_est (
        .x_i     (x_q),
        .q_est_c (q_est_c)
    );

    // Remainder of the estimate and the single-step correction toward 0..9.
    assign r_est_c = REM_W'(x_q) - REM_W'(q_est_c) * TEN_S;
    assign r_adj_c = (r_q < 0) ? r_q + TEN_S : r_q - TEN_S;
    assign q_adj_c = (r_q < 0) ? q_q - WIDTH'(1) : q_q + WIDTH'(1);

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        q_d      = q_q;
        r_d      = r_q;
        fix_d    = fix_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = err_q;
        digits_d = digits_q;
`ifdef LEADING_ZERO_BLANK_EN
        lead_c   = 1'b1;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_d     = value;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_EST;
                end
            end
            S_EST: begin
                q_d     = q_est_c;
                r_d     = r_est_c;
                fix_d   = '0;
                // An estimate that already lands on a digit skips correction.
                state_d = rem_in_range(r_est_c) ? S_STORE : S_FIX;
            end
            S_FIX: begin
                q_d   = q_adj_c;
                r_d   = r_adj_c;
                fix_d = fix_q + FIX_W'(1);
                if (rem_in_range(r_adj_c)) begin
                    state_d = S_STORE;
                end else if (fix_q == FIX_W'(MAX_FIX - 1)) begin
                    err_d   = 1'b1;
                    r_d     = REM_W'(DIGIT_BLANK);
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                digits_d[4*idx_q +: 4] = r_q[3:0];
                x_d     = q_q;
                idx_d   = idx_q + IDX_W'(1);
                state_d = (idx_q == IDX_W'(DIGITS - 1)) ? S_FIN : S_EST;
            end
            S_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
`ifdef LEADING_ZERO_BLANK_EN
                // Blank zeros from the top until the first nonzero digit.
                for (int i = int'(DIGITS) - 1; i > 0; i--) begin
                    if (lead_c && digits_q[4*i +: 4] == 4'h0) begin
                        digits_d[4*i +: 4] = DIGIT_BLANK;
                    end else begin
                        lead_c = 1'b0;
                    end
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            q_q      <= '0;
            r_q      <= '0;
            fix_q    <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            digits_q <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            q_q      <= q_d;
            r_q      <= r_d;
            fix_q    <= fix_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            digits_q <= digits_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign err    = err_q;
    assign digits = digits_q;

endmodule
